sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
Sequences the off-chip 16-bit async SRAM (18-bit halfword address) for the pipeline's LSU.
Converts one 32-bit word request (byte address, byte mask) into up to two 16-bit SRAM half accesses, low half first.
Uses a valid/ready request handshake and a single-cycle response pulse; the LSU stalls the pipeline while o_busy is high.
Sits between inst_lsu and the top-level o_sram_*/io_sram_dq pins.

Parameters:
WAIT_CYC, 1, cycles each half access holds address/strobes (>=1)
SRAM_AW, 18, SRAM halfword address width

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, asynchronous, active-low
i_req_vld  in  1  request valid
o_req_rdy  out  1  controller idle, can accept
i_req_we  in  1  1=write, 0=read
i_req_addr  in  32  byte address; bits [1:0] ignored
i_req_bmask  in  4  byte enables, bit0 = byte 0
i_req_wdata  in  32  write data
o_rsp_vld  out  1  one-cycle completion pulse
o_rsp_rdata  out  32  read data, valid with o_rsp_vld
o_busy  out  1  request in flight
o_sram_addr  out  SRAM_AW  halfword address
io_sram_dq  inout  16  SRAM data bus
o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset values:
  - o_sram_ce_n/oe_n/we_n/lb_n/ub_n = 1.
  - o_sram_addr = 0; io_sram_dq = Z.
  - o_rsp_vld = 0; o_rsp_rdata = 0; o_busy = 0; o_req_rdy = 1.
- FSM states: IDLE, LO, HI, DONE.
  - o_req_rdy = (state==IDLE); o_busy = !o_req_rdy.
- Acceptance:
  - i_req_vld & o_req_rdy at a rising edge captures we, addr, bmask and wdata.
  - Next state: LO if bmask[1:0]!=0; else HI if bmask[3:2]!=0; else DONE.
- Address mapping:
  - o_sram_addr = {addr[18:2], half}, with half = 0 in LO and 1 in HI.
  - addr[31:19] is ignored; the space aliases.
- LO and HI each last exactly WAIT_CYC cycles (internal counter).
  - ce_n = 0 throughout; lb_n = !bmask[2h]; ub_n = !bmask[2h+1], where h = half.
  - Read: oe_n = 0, we_n = 1, dq = Z. dq is sampled into the matching rdata half on the last cycle.
  - Write: oe_n = 1, we_n = 0, dq driven with the wdata half for the whole state.
- LO exit: go to HI if bmask[3:2]!=0, else DONE.
- HI exit: go to DONE.
- Skipped halves and unmasked bytes return 0 in o_rsp_rdata.
- DONE (1 cycle):
  - All strobes high, dq = Z, o_rsp_vld = 1, o_rsp_rdata valid.
  - Always returns to IDLE.
- Response is a one-cycle pulse with no backpressure; writes also pulse o_rsp_vld.
- Latency from acceptance edge to o_rsp_vld high:
  - two halves: 2*WAIT_CYC+1 cycles
  - one half: WAIT_CYC+1 cycles
  - bmask = 0: 1 cycle, no SRAM activity.
- A request presented outside IDLE is held off (rdy = 0); it is never dropped.
- Reset asserted mid-access:
  - Strobes go high and dq goes Z immediately, asynchronously.
  - The transaction is discarded with no o_rsp_vld.
  - The controller is in IDLE when i_rstn releases.
- Strobes never glitch low between states. ce_n returns high for at least one cycle (DONE) between requests.

Optional Feature:
SRAM_CTRL_RDBUF_EN
- Defined: a one-entry read buffer holds addr[18:2] plus data of the last completed read that had bmask = 4'b1111.
  - A later full-mask read of the same word goes IDLE->DONE with no SRAM cycles; latency is 1.
  - Any write to that word, or reset, invalidates the buffer.
- Undefined: no buffer; every read accesses the SRAM.

Decomposition:
- sram_ctrl_pkg:
  - state enum sram_st_e {IDLE, LO, HI, DONE}
  - SRAM_AW, HALF_LO/HALF_HI constants
  - struct sram_req_t {we, addr, bmask, wdata}
- No sub-module. A single FSM plus wait counter, with the dq tristate assign inline.

Test Plan:
- WAIT_CYC=1; write addr 0x10, wdata 0xDEADBEEF, bmask 1111 -> SRAM[0x8]=0xBEEF, SRAM[0x9]=0xDEAD, lb_n=ub_n=0; o_rsp_vld 3 cycles after acceptance.
- Read addr 0x10, bmask 1111 -> o_rsp_rdata 0xDEADBEEF, o_rsp_vld at cycle 3, we_n stays 1, oe_n low for 2 cycles.
- Write addr 0x10, bmask 0100, wdata 0x00AA0000 -> HI only, lb_n=0 ub_n=1, rsp at cycle 2; read back gives 0xDEAABEEF.
- bmask 0000 request -> o_rsp_vld at cycle 1, ce_n never low; back-to-back i_req_vld held -> second request accepted only after the DONE cycle.
- Deassert i_rstn during LO of a write -> we_n/ce_n high in the same cycle, no o_rsp_vld, o_req_rdy=1 after release; SRAM[0x9] unchanged.
- WAIT_CYC=3, full read -> each address held 3 cycles, rsp at cycle 7; with SRAM_CTRL_RDBUF_EN, a repeat read gives rsp at cycle 1 with ce_n high.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM controller
package sram_ctrl_pkg;
   localparam int SRAM_AW = 18;
   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_st_e;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  bmask;
      logic [31:0] wdata;
   } sram_req_t;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits 32-bit LSU word requests into 16-bit async SRAM half accesses, low half first
//   clock/reset : i_clk, i_rstn (async, active-low)
//   request     : i_req_vld/o_req_rdy handshake with i_req_we, i_req_addr, i_req_bmask, i_req_wdata
//   response    : o_rsp_vld one-cycle pulse with o_rsp_rdata; o_busy while a request is in flight
//   sram pins   : o_sram_addr, io_sram_dq, o_sram_ce_n/oe_n/we_n/lb_n/ub_n (active-low)
//   option      : SRAM_CTRL_RDBUF_EN adds a one-entry buffer for the last full-mask read
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYC = 1,
   parameter int SRAM_AW  = sram_ctrl_pkg::SRAM_AW
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_req_vld,
   output logic               o_req_rdy,
   input  logic               i_req_we,
   input  logic [31:0]        i_req_addr,
   input  logic [3:0]         i_req_bmask,
   input  logic [31:0]        i_req_wdata,
   output logic               o_rsp_vld,
   output logic [31:0]        o_rsp_rdata,
   output logic               o_busy,
   output logic [SRAM_AW-1:0] o_sram_addr,
   inout  wire  [15:0]        io_sram_dq,
   output logic               o_sram_ce_n,
   output logic               o_sram_oe_n,
   output logic               o_sram_we_n,
   output logic               o_sram_lb_n,
   output logic               o_sram_ub_n
);
   localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   sram_st_e st, st_nxt;
   sram_req_t req;
   logic [CW-1:0] cnt;
   logic [31:0] rdata, hit_data;
   logic [15:0] rd_half;
   logic acc, act, last, half, hit, unused_ok;
   assign acc  = i_req_vld & (st == IDLE);
   assign act  = (st == LO) | (st == HI);
   assign last = cnt == CW'(WAIT_CYC - 1);
   assign half = (st == HI) ? HALF_HI : HALF_LO;
   assign rd_half = {req.bmask[{half, 1'b1}] ? io_sram_dq[15:8] : 8'h00,
                     req.bmask[{half, 1'b0}] ? io_sram_dq[7:0]  : 8'h00};
   assign io_sram_dq  = (act & req.we) ? (half ? req.wdata[31:16] : req.wdata[15:0]) : 'z;
   assign o_rsp_rdata = rdata;
   assign unused_ok   = ^{req.addr[31:SRAM_AW+1], req.addr[1:0]};
`ifdef SRAM_CTRL_RDBUF_EN
   logic                 buf_vld;
   logic [SRAM_AW-2:0]   buf_addr;
   logic [31:0]          buf_data;
   assign hit = buf_vld & !i_req_we & (i_req_bmask == 4'hF) & (buf_addr == i_req_addr[SRAM_AW:2]);
   assign hit_data = hit ? buf_data : '0;
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
         buf_vld  <= 1'b0;
         buf_addr <= '0;
         buf_data <= '0;
      end else if (acc & i_req_we & (buf_addr == i_req_addr[SRAM_AW:2])) begin
         buf_vld <= 1'b0;
      end else if ((st == DONE) & !req.we & (req.bmask == 4'hF)) begin
         buf_vld  <= 1'b1;
         buf_addr <= req.addr[SRAM_AW:2];
         buf_data <= rdata;
      end
`else
   assign hit = 1'b0;
   assign hit_data = '0;
`endif
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
         st  <= IDLE;
         cnt <= '0;
      end else begin
         st  <= st_nxt;
         cnt <= (act && st_nxt == st) ? cnt + 1'b1 : '0;
      end
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    st_nxt = !i_req_vld ? IDLE : hit ? DONE : |i_req_bmask[1:0] ? LO : |i_req_bmask[3:2] ? HI : DONE;
         LO:      st_nxt = !last ? LO : |req.bmask[3:2] ? HI : DONE;
         HI:      st_nxt = last ? DONE : HI;
         default: st_nxt = IDLE;
      endcase
   end
   always_comb begin
      o_req_rdy   = st == IDLE;
      o_busy      = st != IDLE;
      o_rsp_vld   = st == DONE;
      o_sram_ce_n = !act;
      o_sram_oe_n = !(act & !req.we);
      o_sram_we_n = !(act & req.we);
      o_sram_lb_n = !(act & req.bmask[{half, 1'b0}]);
      o_sram_ub_n = !(act & req.bmask[{half, 1'b1}]);
      o_sram_addr = act ? {req.addr[SRAM_AW:2], half} : '0;
   end
   // rdata is cleared on acceptance so skipped halves and unmasked bytes read back as zero
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
         req   <= '0;
         rdata <= '0;
      end else if (acc) begin
         req   <= '{we: i_req_we, addr: i_req_addr, bmask: i_req_bmask, wdata: i_req_wdata};
         rdata <= hit_data;
      end else if (act & last & !req.we) begin
         if (half) rdata[31:16] <= rd_half;
         else rdata[15:0] <= rd_half;
      end
endmodule
